// File: rtl/dma_block_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_block_writer_pkg
//  Description : Shared definitions for the block-writer DMA: register
//                offsets, STATUS bit positions and the status word builder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_block_writer_pkg;

    // Register indices (byte offset >> 2)
    localparam logic [2:0] REG_ADDR   = 3'd0;
    localparam logic [2:0] REG_STEPS  = 3'd1;
    localparam logic [2:0] REG_CYCLES = 3'd2;
    localparam logic [2:0] REG_BLOCKS = 3'd3;
    localparam logic [2:0] REG_START  = 3'd4;
    localparam logic [2:0] REG_STOP   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam logic [2:0] REG_MATCH  = 3'd7;

    // STATUS register bit positions
    localparam int STAT_BLOCK_DONE = 0;
    localparam int STAT_XFER_DONE  = 1;
    localparam int STAT_MATCH      = 2;

    typedef struct packed {
        logic match;
        logic xfer_done;
        logic block_done;
    } dma_status_t;

    // Pack the engine flags into the CPU-visible STATUS word
    function automatic logic [31:0] status_word(input dma_status_t s);
        logic [31:0] w;
        w                  = '0;
        w[STAT_BLOCK_DONE] = s.block_done;
        w[STAT_XFER_DONE]  = s.xfer_done;
        w[STAT_MATCH]      = s.match;
        return w;
    endfunction

endpackage : dma_block_writer_pkg
`default_nettype wire

// File: rtl/dma_block_writer_regs.sv
`default_nettype none
// ============================================================================
//  Module      : dma_block_writer_regs
//  Description : Wishbone slave register file for the block-writer DMA.
//                Single-cycle ack one clock after the request; accesses take
//                effect in the ack cycle; read data is forced to 0 outside ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_block_writer_regs
    import dma_block_writer_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] ADDR  = 8'h65
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  dma_status_t status_i,
    output logic [31:0] rdt_o,
    output logic        ack_o,
    output logic [31:0] base_o,
    output logic [31:0] cycles_o,
    output logic [31:0] blocks_o,
    output logic [31:0] match_o,
    output logic        start_o,
    output logic        start_repeat_o,
    output logic        stop_o
);

    logic        ack_q;
    logic [31:0] base_q;
    logic [31:0] steps_q;
    logic [31:0] cycles_q;
    logic [31:0] blocks_q;
    logic [31:0] match_q;

    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_wr;
    logic [31:0] w_rdata;
    logic        unused_adr;

    assign w_hit      = cyc_i && (adr_i[31 -: WIDTH] == ADDR);
    assign w_idx      = adr_i[4:2];
    assign w_wr       = ack_q && we_i;
    assign unused_adr = ^{adr_i[1:0], adr_i[31:5]};

    // Ack one clock after a hit; the !ack_q term blocks back-to-back acks
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= w_hit && !ack_q;
        end
    end

    // Storage registers, written in the ack cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q   <= '0;
            steps_q  <= '0;
            cycles_q <= '0;
            blocks_q <= '0;
            match_q  <= '0;
        end else if (w_wr) begin
            case (w_idx)
                REG_ADDR:   base_q   <= dat_i;
                REG_STEPS:  steps_q  <= dat_i;
                REG_CYCLES: cycles_q <= dat_i;
                REG_BLOCKS: blocks_q <= dat_i;
                REG_MATCH:  match_q  <= dat_i;
                default:    ;
            endcase
        end
    end

    // Read mux; START, STOP and anything unmapped read back as zero
    always_comb begin
        w_rdata = '0;
        if (ack_q) begin
            case (w_idx)
                REG_ADDR:   w_rdata = base_q;
                REG_STEPS:  w_rdata = steps_q;
                REG_CYCLES: w_rdata = cycles_q;
                REG_BLOCKS: w_rdata = blocks_q;
                REG_STATUS: w_rdata = status_word(status_i);
                REG_MATCH:  w_rdata = match_q;
                default:    w_rdata = '0;
            endcase
        end
    end

    assign rdt_o          = w_rdata;
    assign ack_o          = ack_q;
    assign base_o         = base_q;
    assign cycles_o       = cycles_q;
    assign blocks_o       = blocks_q;
    assign match_o        = match_q;
    assign start_o        = w_wr && (w_idx == REG_START);
    assign start_repeat_o = dat_i[0];
    assign stop_o         = w_wr && (w_idx == REG_STOP);

endmodule : dma_block_writer_regs
`default_nettype wire

// File: rtl/dma_block_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dma_block_writer
//  Description : Wishbone DMA engine. Per xfer_block pulse it reads CYCLES
//                16-bit samples from the local source port and writes each
//                one, zero-extended, to consecutive 32-bit words in memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_block_writer
    import dma_block_writer_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] ADDR        = 8'h65,
    parameter int               XFER_ADDR_W = 16
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic                   wb_dbus_cyc,
    input  logic                   wb_dbus_we,
    input  logic [31:0]            wb_dbus_adr,
    input  logic [31:0]            wb_dbus_dat,
    output logic [31:0]            dbus_rdt,
    output logic                   dbus_ack,
    input  logic                   xfer_block,
    output logic [XFER_ADDR_W-1:0] xfer_adr,
    input  logic [15:0]            xfer_dat,
    output logic                   xfer_re,
    output logic                   block_done,
    output logic                   xfer_done,
    output logic                   dma_cyc,
    output logic                   dma_we,
    output logic [3:0]             dma_sel,
    output logic [31:0]            dma_adr,
    output logic [31:0]            dma_dat,
    input  logic                   dma_ack,
    input  logic [31:0]            dma_rdt
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_BLOCK = 3'd1;
    localparam logic [2:0] S_READ       = 3'd2;
    localparam logic [2:0] S_WRITE      = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]  state_q,      state_d;
    logic [31:0] blk_q,        blk_d;
    logic [31:0] c_q,          c_d;
    logic [31:0] n_q,          n_d;
    logic [15:0] sample_q,     sample_d;
    logic        block_done_q, block_done_d;
    logic        xfer_done_q,  xfer_done_d;
    logic        match_q,      match_d;
    logic        repeat_q,     repeat_d;

    logic [31:0] w_cfg_base;
    logic [31:0] w_cfg_cycles;
    logic [31:0] w_cfg_blocks;
    logic [31:0] w_cfg_match;
    logic        w_start;
    logic        w_start_repeat;
    logic        w_stop;
    dma_status_t w_status;
    logic [31:0] w_dma_adr;
    logic        w_last_sample;
    logic        w_last_block;
    logic        w_in_write;
    logic        unused_rdt;

    assign w_status   = '{match: match_q, xfer_done: xfer_done_q, block_done: block_done_q};
    assign unused_rdt = ^dma_rdt;

    dma_block_writer_regs #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_regs (
        .clk_i          (wb_clk),
        .rst_i          (wb_rst),
        .cyc_i          (wb_dbus_cyc),
        .we_i           (wb_dbus_we),
        .adr_i          (wb_dbus_adr),
        .dat_i          (wb_dbus_dat),
        .status_i       (w_status),
        .rdt_o          (dbus_rdt),
        .ack_o          (dbus_ack),
        .base_o         (w_cfg_base),
        .cycles_o       (w_cfg_cycles),
        .blocks_o       (w_cfg_blocks),
        .match_o        (w_cfg_match),
        .start_o        (w_start),
        .start_repeat_o (w_start_repeat),
        .stop_o         (w_stop)
    );

    // n counts words written since the last (re)start, so it sets the address
    assign w_dma_adr     = w_cfg_base + (n_q << 2);
    // >= rather than == so a CPU shrinking CYCLES/BLOCKS mid-run cannot strand us
    assign w_last_sample = (c_q + 32'd1) >= w_cfg_cycles;
    assign w_last_block  = (blk_q + 32'd1) >= w_cfg_blocks;
    assign w_in_write    = (state_q == S_WRITE);

    // Engine next-state: STOP beats START beats normal sequencing
    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        c_d          = c_q;
        n_d          = n_q;
        sample_d     = sample_q;
        block_done_d = block_done_q;
        xfer_done_d  = xfer_done_q;
        match_d      = match_q;
        repeat_d     = repeat_q;

        if (w_stop) begin
            state_d      = S_IDLE;
            block_done_d = 1'b0;
            xfer_done_d  = 1'b0;
            match_d      = 1'b0;
        end else if (w_start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            blk_d        = '0;
            c_d          = '0;
            n_d          = '0;
            block_done_d = 1'b0;
            match_d      = 1'b0;
            repeat_d     = w_start_repeat;
            xfer_done_d  = (w_cfg_blocks == 32'd0);
            state_d      = (w_cfg_blocks == 32'd0) ? S_DONE : S_WAIT_BLOCK;
        end else begin
            if (w_start) begin
                repeat_d = w_start_repeat;
            end
            case (state_q)
                S_WAIT_BLOCK: begin
                    if (xfer_block) begin
                        block_done_d = 1'b0;
                        c_d          = '0;
                        if (w_cfg_cycles == 32'd0) begin
                            block_done_d = 1'b1;
                            blk_d        = blk_q + 32'd1;
                            xfer_done_d  = w_last_block;
                            state_d      = w_last_block ? S_DONE : S_WAIT_BLOCK;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
                S_READ: begin
                    sample_d = xfer_dat;
                    state_d  = S_WRITE;
                end
                S_WRITE: begin
                    if (dma_ack) begin
                        n_d = n_q + 32'd1;
                        if (w_dma_adr == w_cfg_match) begin
                            match_d = 1'b1;
                        end
                        if (w_last_sample) begin
                            block_done_d = 1'b1;
                            blk_d        = blk_q + 32'd1;
                            xfer_done_d  = w_last_block;
                            state_d      = w_last_block ? S_DONE : S_WAIT_BLOCK;
                        end else begin
                            c_d     = c_q + 32'd1;
                            state_d = S_READ;
                        end
                    end
                end
                S_DONE: begin
                    // Repeat mode: xfer_done has been visible for one cycle, restart
                    if (repeat_q) begin
                        blk_d        = '0;
                        c_d          = '0;
                        n_d          = '0;
                        block_done_d = 1'b0;
                        match_d      = 1'b0;
                        xfer_done_d  = (w_cfg_blocks == 32'd0);
                        state_d      = (w_cfg_blocks == 32'd0) ? S_DONE : S_WAIT_BLOCK;
                    end
                end
                default: ;
            endcase
        end
    end

    // Engine state registers
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= S_IDLE;
            blk_q        <= '0;
            c_q          <= '0;
            n_q          <= '0;
            sample_q     <= '0;
            block_done_q <= 1'b0;
            xfer_done_q  <= 1'b0;
            match_q      <= 1'b0;
            repeat_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            c_q          <= c_d;
            n_q          <= n_d;
            sample_q     <= sample_d;
            block_done_q <= block_done_d;
            xfer_done_q  <= xfer_done_d;
            match_q      <= match_d;
            repeat_q     <= repeat_d;
        end
    end

    assign xfer_re    = (state_q == S_READ);
    assign xfer_adr   = xfer_re ? c_q[XFER_ADDR_W-1:0] : '0;
    assign block_done = block_done_q;
    assign xfer_done  = xfer_done_q;
    assign dma_cyc    = w_in_write;
    assign dma_we     = w_in_write;
    assign dma_sel    = w_in_write ? 4'b1111 : 4'b0000;
    assign dma_adr    = w_in_write ? w_dma_adr : '0;
    assign dma_dat    = w_in_write ? {16'h0000, sample_q} : '0;

endmodule : dma_block_writer
`default_nettype wire

// File: tb/tb_dma_block_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dma_block_writer
//  Description : Self-checking bench for dma_block_writer with a memory
//                responder and a transfer-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_block_writer;

    localparam logic [4:0] O_ADDR   = 5'h00;
    localparam logic [4:0] O_STEPS  = 5'h04;
    localparam logic [4:0] O_CYCLES = 5'h08;
    localparam logic [4:0] O_BLOCKS = 5'h0C;
    localparam logic [4:0] O_START  = 5'h10;
    localparam logic [4:0] O_STOP   = 5'h14;
    localparam logic [4:0] O_STATUS = 5'h18;
    localparam logic [4:0] O_MATCH  = 5'h1C;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        wb_dbus_cyc, wb_dbus_we;
    logic [31:0] wb_dbus_adr, wb_dbus_dat;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic        xfer_block;
    logic [15:0] xfer_adr;
    logic [15:0] xfer_dat;
    logic        xfer_re, block_done, xfer_done;
    logic        dma_cyc, dma_we;
    logic [3:0]  dma_sel;
    logic [31:0] dma_adr, dma_dat;
    logic        dma_ack;
    logic [31:0] dma_rdt;

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    int          src_mode      = 0;
    logic [15:0] src_seed      = 16'h0;
    int          ack_wait      = 0;

    typedef struct packed { logic [31:0] adr; logic [31:0] dat; } wr_t;
    wr_t got_q[$];
    wr_t exp_q[$];

    always #5 wb_clk = ~wb_clk;

    dma_block_writer dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .wb_dbus_cyc (wb_dbus_cyc),
        .wb_dbus_we  (wb_dbus_we),
        .wb_dbus_adr (wb_dbus_adr),
        .wb_dbus_dat (wb_dbus_dat),
        .dbus_rdt    (dbus_rdt),
        .dbus_ack    (dbus_ack),
        .xfer_block  (xfer_block),
        .xfer_adr    (xfer_adr),
        .xfer_dat    (xfer_dat),
        .xfer_re     (xfer_re),
        .block_done  (block_done),
        .xfer_done   (xfer_done),
        .dma_cyc     (dma_cyc),
        .dma_we      (dma_we),
        .dma_sel     (dma_sel),
        .dma_adr     (dma_adr),
        .dma_dat     (dma_dat),
        .dma_ack     (dma_ack),
        .dma_rdt     (dma_rdt)
    );

    // Sample source: a pure function of the sample index
    function automatic logic [15:0] src_sample(input int mode, input logic [15:0] seed, input int c);
        logic [15:0] v;
        if (mode == 0) begin
            v = 16'h1111;
            v = v << c;
        end else begin
            v = 16'(c * 40503) ^ seed;
        end
        return v;
    endfunction

    assign xfer_dat = xfer_re ? src_sample(src_mode, src_seed, int'(xfer_adr)) : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus-level invariants checked every cycle
    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (!dbus_ack) check("rdt_without_ack", dbus_rdt, 32'h0);
            if (dma_cyc) begin
                check("dma_we", 32'(dma_we), 32'h1);
                check("dma_sel", 32'(dma_sel), 32'hF);
            end
        end
    end

    // Memory responder: random 0..2 cycle ack latency, logs every accepted write
    initial begin
        dma_ack = 1'b0;
        dma_rdt = 32'hDEAD_BEEF;
        forever begin
            @(posedge wb_clk);
            #1;
            if (dma_ack) begin
                dma_ack = 1'b0;
            end else if (dma_cyc && !wb_rst) begin
                if (ack_wait == 0) begin
                    dma_ack = 1'b1;
                    got_q.push_back('{adr: dma_adr, dat: dma_dat});
                    ack_wait = $urandom_range(0, 2);
                end else begin
                    ack_wait--;
                end
            end
        end
    end

    // Called just after a negedge; returns just after a negedge
    task automatic wb_access(input bit we, input logic [4:0] off, input logic [31:0] wdat,
                             output logic [31:0] rdat);
        int lat;
        lat         = 99;
        wb_dbus_adr = {8'h65, 19'h0, off};
        wb_dbus_we  = we;
        wb_dbus_dat = wdat;
        wb_dbus_cyc = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge wb_clk);
            if (dbus_ack) begin
                lat = k;
                break;
            end
        end
        check("wb_ack_latency", 32'(lat), 32'h0);
        rdat = dbus_rdt;
        @(posedge wb_clk);
        #1;
        wb_dbus_cyc = 1'b0;
        wb_dbus_we  = 1'b0;
        @(negedge wb_clk);
        check("wb_single_ack", 32'(dbus_ack), 32'h0);
    endtask

    task automatic wb_write(input logic [4:0] off, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_access(1'b1, off, wdat, dummy);
    endtask

    task automatic wb_check(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(1'b0, off, 32'h0, r);
        check(tag, r, exp);
    endtask

    task automatic run_block();
        xfer_block = 1'b1;
        @(negedge wb_clk);
        xfer_block = 1'b0;
        for (int k = 0; k < 4000 && !block_done; k++) @(negedge wb_clk);
        check("block_done", 32'(block_done), 32'h1);
    endtask

    // Reference model: the whole transfer expressed as a list of memory writes
    function automatic bit model_transfer(input logic [31:0] base, input int cycles, input int blocks,
                                          input logic [31:0] match, input int mode, input logic [15:0] seed);
        bit hit;
        hit = 1'b0;
        for (int b = 0; b < blocks; b++) begin
            for (int c = 0; c < cycles; c++) begin
                wr_t w;
                w.adr = base + 32'((b * cycles + c) * 4);
                w.dat = {16'h0, src_sample(mode, seed, c)};
                if (w.adr == match) hit = 1'b1;
                exp_q.push_back(w);
            end
        end
        return hit;
    endfunction

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_adr"}, got_q[i].adr, exp_q[i].adr);
            check({tag, "_dat"}, got_q[i].dat, exp_q[i].dat);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          exp_match;
        int          cyc_seen;
        int          rc, rb;
        logic [31:0] rbase, rmatch;

        wb_rst      = 1'b1;
        wb_dbus_cyc = 1'b0;
        wb_dbus_we  = 1'b0;
        wb_dbus_adr = '0;
        wb_dbus_dat = '0;
        xfer_block  = 1'b0;
        repeat (4) @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);

        // Reset state
        check("reset_outputs", {26'h0, xfer_re, block_done, xfer_done, dma_cyc, dma_adr[0], dma_dat[0]}, 32'h0);
        for (int i = 0; i < 8; i++) wb_check("reset_read", 5'(i * 4), 32'h0);

        // Main transfer: 8 blocks of 16 samples
        wb_write(O_ADDR,   32'h0001_0000);
        wb_write(O_MATCH,  32'h0001_0010);
        wb_write(O_STEPS,  32'h0000_1000);
        wb_write(O_CYCLES, 32'h10);
        wb_write(O_BLOCKS, 32'h8);
        wb_write(O_START,  32'h0);
        src_mode  = 0;
        exp_match = model_transfer(32'h0001_0000, 16, 8, 32'h0001_0010, 0, 16'h0);
        for (int b = 0; b < 8; b++) run_block();
        check("xfer_done_main", 32'(xfer_done), 32'h1);
        compare_writes("main");
        wb_check("status_main", O_STATUS, {29'h0, exp_match, 2'b11});
        wb_check("rb_addr",   O_ADDR,   32'h0001_0000);
        wb_check("rb_steps",  O_STEPS,  32'h0000_1000);
        wb_check("rb_cycles", O_CYCLES, 32'h10);
        wb_check("rb_blocks", O_BLOCKS, 32'h8);
        wb_check("rb_match",  O_MATCH,  32'h0001_0010);
        wb_check("rb_start",  O_START,  32'h0);
        wb_check("rb_stop",   O_STOP,   32'h0);

        // Pulse while done: no bus activity, flags hold
        cyc_seen   = 0;
        xfer_block = 1'b1;
        @(negedge wb_clk);
        xfer_block = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dma_cyc) cyc_seen++;
            @(negedge wb_clk);
        end
        check("done_ignores_block", 32'(cyc_seen), 32'h0);
        check("done_flags_hold", {30'h0, xfer_done, block_done}, 32'h3);

        // STOP clears status; restart repeats the identical transfer
        wb_write(O_STOP, 32'hFFFF_FFFF);
        wb_check("status_after_stop", O_STATUS, 32'h0);
        wb_write(O_START, 32'h0);
        exp_match = model_transfer(32'h0001_0000, 16, 8, 32'h0001_0010, 0, 16'h0);
        for (int b = 0; b < 8; b++) run_block();
        compare_writes("rerun");
        wb_check("status_rerun", O_STATUS, {29'h0, exp_match, 2'b11});

        // Mid-block STOP aborts the write in flight
        wb_write(O_START, 32'h0);
        xfer_block = 1'b1;
        @(negedge wb_clk);
        xfer_block = 1'b0;
        for (int k = 0; k < 200 && got_q.size() < 3; k++) @(negedge wb_clk);
        for (int k = 0; k < 20 && !dma_cyc; k++) @(negedge wb_clk);
        check("midblock_busy", 32'(dma_cyc), 32'h1);
        wb_write(O_STOP, 32'h0);
        check("stop_drops_cyc", 32'(dma_cyc), 32'h0);
        check("stop_flags", {30'h0, xfer_done, block_done}, 32'h0);
        repeat (3) @(negedge wb_clk);
        check("stop_stays_idle", 32'(dma_cyc), 32'h0);
        wb_check("status_midstop", O_STATUS, 32'h0);
        got_q.delete();

        // Repeat mode: auto-restart, then clear repeat while running
        wb_write(O_CYCLES, 32'h4);
        wb_write(O_BLOCKS, 32'h4);
        wb_write(O_MATCH,  32'h0001_0004);
        wb_write(O_START,  32'h1);
        void'(model_transfer(32'h0001_0000, 4, 4, 32'h0001_0004, 0, 16'h0));
        for (int b = 0; b < 4; b++) run_block();
        check("repeat_done_pulse", 32'(xfer_done), 32'h1);
        @(negedge wb_clk);
        check("repeat_restarted", {30'h0, xfer_done, block_done}, 32'h0);
        wb_write(O_START, 32'h0);
        exp_match = model_transfer(32'h0001_0000, 4, 4, 32'h0001_0004, 0, 16'h0);
        for (int b = 0; b < 4; b++) run_block();
        check("norepeat_done", 32'(xfer_done), 32'h1);
        repeat (5) @(negedge wb_clk);
        check("norepeat_done_held", 32'(xfer_done), 32'h1);
        compare_writes("repeat");
        wb_check("status_repeat", O_STATUS, {29'h0, exp_match, 2'b11});

        // Randomised transfers, including CYCLES=0 and BLOCKS=0
        for (int t = 0; t < 6; t++) begin
            rc       = (t == 0) ? 0 : $urandom_range(1, 6);
            rb       = (t == 1) ? 0 : $urandom_range(1, 4);
            rbase    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} ^ {$urandom_range(0, 3), 30'h0};
            src_mode = 1;
            src_seed = 16'($urandom);
            if ((rc * rb > 0) && ($urandom_range(0, 1) == 1))
                rmatch = rbase + 32'($urandom_range(0, rc * rb - 1) * 4);
            else
                rmatch = rbase - 32'h4;
            wb_write(O_ADDR,   rbase);
            wb_write(O_CYCLES, 32'(rc));
            wb_write(O_BLOCKS, 32'(rb));
            wb_write(O_MATCH,  rmatch);
            wb_write(O_START,  32'h0);
            exp_match = model_transfer(rbase, rc, rb, rmatch, 1, src_seed);
            for (int b = 0; b < rb; b++) run_block();
            repeat (3) @(negedge wb_clk);
            check("rand_xfer_done", 32'(xfer_done), 32'h1);
            compare_writes("rand");
            wb_check("rand_status", O_STATUS, {29'h0, exp_match, 1'b1, (rb > 0)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_dma_block_writer
`default_nettype wire
